// File: rtl/handshake_pkg.sv
// Shared state encodings and default widths for the handshake blocks.
package handshake_pkg;

  // One-bit arbiter state: waiting for a request, or forwarding a burst.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Default sizing used across the handshake blocks.
  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_BURST_LEN = 16;

endpackage

// File: rtl/handshake_arbiter_rr_pick.sv
// Round-robin pick: first set request bit at or after ptr_i, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [ID_W-1:0]  winner_o,
  output logic             any_o
);

  localparam int SUM_W = ID_W + 1;
  localparam logic [SUM_W-1:0] N_VAL = SUM_W'(N_REQ);

  logic [2*N_REQ-1:0] dbl_req;
  logic [N_REQ-1:0]   rot_req;
  logic [ID_W-1:0]    sel;
  logic [SUM_W-1:0]   sum;

  // Rotate so that ptr_i lands at bit 0; doubling the vector makes the wrap free.
  assign dbl_req = {req_i, req_i};
  assign rot_req = N_REQ'(dbl_req >> ptr_i);
  assign any_o   = |req_i;

  // Priority-encode the rotated vector, then undo the rotation modulo N_REQ.
  always_comb begin
    sel = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) sel = ID_W'(k);
    end
    sum = {1'b0, ptr_i} + {1'b0, sel};
    if (sum >= N_VAL) sum = sum - N_VAL;
    winner_o = sum[ID_W-1:0];
  end

endmodule

// File: rtl/handshake_arbiter.sv
// Round-robin arbiter sharing one valid/ready sink between N_REQ sources,
// holding each grant for up to BURST_LEN accepted beats.
module handshake_arbiter
  import handshake_pkg::*;
#(
  parameter  int N_REQ     = DEF_N_REQ,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int BURST_LEN = DEF_BURST_LEN,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_vaild,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_vaild,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [ID_W-1:0]   winner;
  logic              any_req;
  logic              granted_vld;
  logic [DATA_W-1:0] granted_data;
  logic              beat;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req_i    (req_vaild),
    .ptr_i    (rr_ptr_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  assign granted_vld  = req_vaild[grant_q];
  assign granted_data = req_data[grant_q*DATA_W +: DATA_W];
  assign grant_id     = grant_q;
  assign busy         = (state_q == ST_BUSY);

  // State register; reset aborts any burst in progress.
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state and output mux; the sink only ever sees the granted source.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    out_vaild  = 1'b0;
    out_data   = '0;
    req_ready  = '0;
    beat       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d    = winner;
          beat_cnt_d = '0;
          state_d    = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // Handshake outputs are suppressed while reset is held so no beat
        // can be accepted in the cycle that aborts the burst.
        if (reset) begin
          out_vaild          = granted_vld;
          out_data           = granted_data;
          req_ready[grant_q] = out_ready;
        end
        beat = granted_vld & out_ready;

        if (!granted_vld || (beat && beat_cnt_q == LAST_BEAT)) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_handshake_arbiter.sv
// Scoreboard bench: expected beats are queued as stimulus is applied and
// popped as each DUT forwards a beat downstream.
module tb_handshake_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  // DUT 0: BURST_LEN = 16
  logic [3:0]  vld0 = '0;
  logic [31:0] data0;
  logic [3:0]  rdy0;
  logic        ovld0;
  logic [7:0]  odata0;
  logic        ordy0 = 1'b0;
  logic [1:0]  gid0;
  logic        busy0;

  // DUT 1: BURST_LEN = 1
  logic [3:0]  vld1 = '0;
  logic [31:0] data1;
  logic [3:0]  rdy1;
  logic        ovld1;
  logic [7:0]  odata1;
  logic        ordy1 = 1'b0;
  logic [1:0]  gid1;
  logic        busy1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [5:0] cnt0 [4] = '{default: 6'd0};
  logic [5:0] cnt1 [4] = '{default: 6'd0};
  logic [5:0] exp_seq0 [4] = '{default: 6'd0};
  logic [5:0] exp_seq1 [4] = '{default: 6'd0};
  logic [9:0] q0 [$];
  logic [9:0] q1 [$];

  always #5 clk = ~clk;

  handshake_arbiter #(.N_REQ(4), .DATA_W(8), .BURST_LEN(16)) dut (
    .sys_clk   (clk),
    .reset     (rstn),
    .req_vaild (vld0),
    .req_data  (data0),
    .req_ready (rdy0),
    .out_vaild (ovld0),
    .out_data  (odata0),
    .out_ready (ordy0),
    .grant_id  (gid0),
    .busy      (busy0)
  );

  handshake_arbiter #(.N_REQ(4), .DATA_W(8), .BURST_LEN(1)) dut1 (
    .sys_clk   (clk),
    .reset     (rstn),
    .req_vaild (vld1),
    .req_data  (data1),
    .req_ready (rdy1),
    .out_vaild (ovld1),
    .out_data  (odata1),
    .out_ready (ordy1),
    .grant_id  (gid1),
    .busy      (busy1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source models: each beat carries {source id, running sequence number}.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      data0[i*8 +: 8] = {2'(i), cnt0[i]};
      data1[i*8 +: 8] = {2'(i), cnt1[i]};
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vld0[i] && rdy0[i]) cnt0[i] <= cnt0[i] + 6'd1;
      if (vld1[i] && rdy1[i]) cnt1[i] <= cnt1[i] + 6'd1;
    end
  end

  task automatic push0(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      q0.push_back({2'(id), 2'(id), exp_seq0[id]});
      exp_seq0[id] = exp_seq0[id] + 6'd1;
    end
  endtask

  task automatic push1(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      q1.push_back({2'(id), 2'(id), exp_seq1[id]});
      exp_seq1[id] = exp_seq1[id] + 6'd1;
    end
  endtask

  // Downstream monitors: one line per accepted beat, checked against the queue.
  always @(negedge clk) begin
    logic [9:0] e;
    if (ovld0 && ordy0) begin
      if (q0.size() == 0) check_eq("dut0_extra_beat", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        check_eq("dut0_beat_id", 32'(gid0), 32'(e[9:8]));
        check_eq("dut0_beat_data", 32'(odata0), 32'(e[7:0]));
        $display("[TB] dut0 beat id=%0d data=%02h", gid0, odata0);
      end
    end
    if (busy0) check_eq("dut0_ready_nongranted", 32'(rdy0 & ~(4'b0001 << gid0)), 32'd0);
    if (ovld1 && ordy1) begin
      if (q1.size() == 0) check_eq("dut1_extra_beat", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check_eq("dut1_beat_id", 32'(gid1), 32'(e[9:8]));
        check_eq("dut1_beat_data", 32'(odata1), 32'(e[7:0]));
        $display("[TB] dut1 beat id=%0d data=%02h", gid1, odata1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rstn = 1'b0;
    vld0 = '0;
    vld1 = '0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      samp();
    end
  endtask

  initial begin
    int order2 [5];
    int order6 [4];
    logic [3:0] pat;
    int accepted;
    order2 = '{0, 1, 2, 3, 0};
    order6 = '{0, 3, 0, 3};
    pat = 4'b1001;

    // Reset state
    tick();
    samp();
    check_eq("rst_out_vaild", 32'(ovld0), 32'd0);
    check_eq("rst_out_data", 32'(odata0), 32'd0);
    check_eq("rst_req_ready", 32'(rdy0), 32'd0);
    check_eq("rst_busy", 32'(busy0), 32'd0);
    check_eq("rst_grant_id", 32'(gid0), 32'd0);
    rstn = 1'b1;

    // 1: single requester, re-grant, rr_ptr advances past it
    ordy0 = 1'b1;
    push0(2, 32);
    tick(); vld0 = 4'b0100; samp();
    check_eq("t1_idle_first", 32'(busy0), 32'd0);
    tick(); samp();
    check_eq("t1_busy", 32'(busy0), 32'd1);
    check_eq("t1_grant", 32'(gid0), 32'd2);
    run_cycles(15);
    tick(); samp();
    check_eq("t1_gap", 32'(busy0), 32'd0);
    tick(); samp();
    check_eq("t1_regrant", 32'(gid0), 32'd2);
    check_eq("t1_regrant_busy", 32'(busy0), 32'd1);
    run_cycles(15);
    tick(); vld0 = 4'b1100; samp();
    check_eq("t1_gap2", 32'(busy0), 32'd0);
    tick(); vld0 = 4'b0000; samp();
    check_eq("t1_rrptr_grant", 32'(gid0), 32'd3);
    check_eq("t1_drop_vaild", 32'(ovld0), 32'd0);
    tick(); samp();
    check_eq("t1_end_idle", 32'(busy0), 32'd0);

    // 2: round-robin fairness, 16 beats per grant, one idle cycle between
    do_reset();
    for (int g = 0; g < 5; g++) push0(order2[g], 16);
    tick(); vld0 = 4'b1111; samp();
    check_eq("t2_idle_first", 32'(busy0), 32'd0);
    for (int g = 0; g < 5; g++) begin
      tick(); samp();
      check_eq("t2_grant", 32'(gid0), 32'(order2[g]));
      check_eq("t2_busy", 32'(busy0), 32'd1);
      run_cycles(15);
      tick();
      if (g == 4) vld0 = 4'b0000;
      samp();
      check_eq("t2_gap", 32'(busy0), 32'd0);
    end

    // 3: early release when the granted source drops vaild
    do_reset();
    push0(1, 5);
    push0(3, 16);
    tick(); vld0 = 4'b1010; samp();
    tick(); samp();
    check_eq("t3_grant1", 32'(gid0), 32'd1);
    run_cycles(4);
    tick(); vld0 = 4'b1000; samp();
    check_eq("t3_drop_busy", 32'(busy0), 32'd1);
    check_eq("t3_drop_vaild", 32'(ovld0), 32'd0);
    tick(); samp();
    check_eq("t3_gap", 32'(busy0), 32'd0);
    tick(); samp();
    check_eq("t3_grant3", 32'(gid0), 32'd3);
    run_cycles(15);
    tick(); vld0 = 4'b0000; samp();
    check_eq("t3_full_burst_end", 32'(busy0), 32'd0);

    // 4: back-pressure holds the beat count
    do_reset();
    push0(0, 16);
    ordy0 = 1'b0;
    tick(); vld0 = 4'b0001; samp();
    accepted = 0;
    for (int k = 0; k < 64 && accepted < 16; k++) begin
      tick(); ordy0 = pat[k % 4]; samp();
      check_eq("t4_busy", 32'(busy0), 32'd1);
      check_eq("t4_ready", 32'(rdy0), {31'd0, ordy0});
      if (ordy0) accepted++;
    end
    tick(); ordy0 = 1'b1; vld0 = 4'b0000; samp();
    check_eq("t4_release", 32'(busy0), 32'd0);

    // 5: reset in the middle of a burst
    do_reset();
    push0(2, 7);
    tick(); vld0 = 4'b0100; samp();
    run_cycles(7);
    tick(); rstn = 1'b0; samp();
    check_eq("t5_rst_cycle_ready", 32'(rdy0), 32'd0);
    check_eq("t5_rst_cycle_vaild", 32'(ovld0), 32'd0);
    tick(); samp();
    check_eq("t5_state_idle", 32'(busy0), 32'd0);
    check_eq("t5_vaild", 32'(ovld0), 32'd0);
    check_eq("t5_ready", 32'(rdy0), 32'd0);
    check_eq("t5_grant_rst", 32'(gid0), 32'd0);
    push0(0, 1);
    tick(); rstn = 1'b1; vld0 = 4'b1111; samp();
    check_eq("t5_idle_after", 32'(busy0), 32'd0);
    tick(); samp();
    check_eq("t5_grant0", 32'(gid0), 32'd0);
    check_eq("t5_busy", 32'(busy0), 32'd1);
    tick(); vld0 = 4'b0000; samp();
    check_eq("t5_drop_vaild", 32'(ovld0), 32'd0);
    tick(); samp();

    // 6: BURST_LEN=1 alternates single-beat grants
    ordy1 = 1'b1;
    for (int g = 0; g < 4; g++) push1(order6[g], 1);
    tick(); vld1 = 4'b1001; samp();
    check_eq("t6_idle_first", 32'(busy1), 32'd0);
    for (int g = 0; g < 4; g++) begin
      tick(); samp();
      check_eq("t6_grant", 32'(gid1), 32'(order6[g]));
      check_eq("t6_busy", 32'(busy1), 32'd1);
      tick();
      if (g == 3) vld1 = 4'b0000;
      samp();
      check_eq("t6_gap", 32'(busy1), 32'd0);
    end

    run_cycles(2);
    check_eq("q0_drained", 32'(q0.size()), 32'd0);
    check_eq("q1_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/handshake_arbiter.md
Name: handshake_arbiter

Overview:
- Round-robin arbiter that shares one downstream vaild/ready sink between N_REQ upstream vaild/ready data sources, e.g. several master instances feeding one slave.
- The grant is held for a burst of up to BURST_LEN accepted beats. It is released early when the granted source drops vaild.
- Ready back-pressure passes through to the granted source only. Non-granted sources see ready low.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 8, data width per requester.
- BURST_LEN, 16, maximum accepted beats per grant (>=1).
- ID_W, $clog2(N_REQ), grant index width (derived; not overridden).

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_vaild  in  N_REQ  per-requester vaild; bit i = requester i.
- req_data  in  N_REQ*DATA_W  packed data; slice i = [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  per-requester ready.
- out_vaild  out  1  vaild to downstream sink.
- out_data  out  DATA_W  data to downstream sink.
- out_ready  in  1  downstream ready.
- grant_id  out  ID_W  index of the currently granted requester.
- busy  out  1  high while in BUSY.

Behaviour:
- Reset (reset==0 at an edge):
  - State=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0.
  - Outputs at reset: out_vaild=0, out_data=0, req_ready=0, busy=0.
  - Reset mid-burst aborts the burst. No beat is accepted in the reset cycle.
- State register: 1 bit, ST_IDLE / ST_BUSY.
- IDLE:
  - out_vaild=0, out_data=0, req_ready=0.
  - If any req_vaild bit is set, the winner is the first set bit searching i = rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - At the next edge: grant_id<=winner, beat_cnt<=0, state<=BUSY.
  - Arbitration latency: a request seen in IDLE at cycle t gives out_vaild at t+1 at the earliest.
- BUSY (combinational mux on the registered grant_id):
  - out_vaild=req_vaild[grant_id], out_data=req_data[grant_id].
  - req_ready[grant_id]=out_ready; all other req_ready bits = 0.
  - A beat is counted on out_vaild & out_ready.
- Release from BUSY to IDLE, with rr_ptr<=(grant_id+1) mod N_REQ, when either:
  - (a) a beat completes with beat_cnt==BURST_LEN-1, or
  - (b) req_vaild[grant_id]==0 in any BUSY cycle.
- If neither release condition holds and a beat completes, beat_cnt<=beat_cnt+1.
- Width and wrap rules:
  - beat_cnt width is $clog2(BURST_LEN+1).
  - rr_ptr wraps from N_REQ-1 to 0.
- Switch gap: after a release at cycle t, state is IDLE at t+1 and the next grant is effective at t+2. The minimum bubble between grants is 1 cycle.
- Boundary conditions:
  - BURST_LEN==1: release after every accepted beat.
  - Back-pressure: out_ready low holds beat_cnt. The grant persists while req_vaild[grant_id] stays high, with no timeout.
  - Non-granted requesters are never acknowledged. Their data is never forwarded.
  - Final beat and vaild drop never coincide as separate events. A vaild-drop cycle carries no beat, so release (b) alone applies.
  - Only one requester active: it is re-granted after every release, with a 1-cycle IDLE gap each time.
  - Requests arriving during BUSY are recorded nowhere. They are sampled only in IDLE; requesters must hold vaild.
- Registered state: state, grant_id, rr_ptr, beat_cnt. out_* and req_ready are combinational from these and the inputs. busy = (state==ST_BUSY).

Decomposition:
- Shared package/header handshake_pkg holds:
  - the state encodings ST_IDLE=1'b0, ST_BUSY=1'b1;
  - the default widths used across the handshake blocks.
- One combinational sub-module, rr_pick (parameters N_REQ, ID_W):
  - inputs: request vector, rr_ptr;
  - outputs: winner index, any-request flag;
  - implementation: rotate, priority encode, un-rotate.

Test Plan:
1. Single requester: N_REQ=4, BURST_LEN=16, req_vaild=4'b0100 steady, out_ready=1. Required: grant_id=2 one cycle after request; 16 beats forwarded; IDLE for 1 cycle; re-grant to 2; rr_ptr=3 after release.
2. Round-robin fairness: all four vaild held high, out_ready=1. Required: grants in order 0,1,2,3,0, each exactly 16 beats, with exactly 1 idle cycle between grants.
3. Early release: requester 1 granted and drops vaild after 5 accepted beats while requester 3 is waiting. Required: release in the vaild-low cycle; grant_id=3 two cycles later; beat_cnt restarts at 0.
4. Back-pressure: requester 0 granted; out_ready toggles 1,0,0,1 repeatedly. Required: req_ready[0] mirrors out_ready; all other req_ready bits 0; beat_cnt advances only on ready cycles; release only after the 16th accepted beat.
5. Reset mid-burst: reset=0 asserted at beat 7 of a grant to requester 2. Required: at the next edge state=IDLE, out_vaild=0, req_ready=0, rr_ptr=0; after reset release with all vaild high, grant_id=0.
6. BURST_LEN=1, requesters 0 and 3 vaild. Required: alternating single-beat grants 0,3,0,3, with out_data equal to the respective requester's data slice on each beat.
